// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: shared CPU-side constants and fetch FSM encoding.
// Imported by the fetch stage and its instruction buffer.
package instruction_fetch_pkg;

   localparam int DATA_WIDTH = 32;
   localparam logic [DATA_WIDTH-1:0] RESET_PC = '0;

   // RUN: responses go to the buffer.
   // DRAIN: stale responses from before a redirect are dropped.
   typedef enum logic {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_sync_fifo.sv
// sync_fifo: registered-storage FIFO with push/pop/flush and occupancy count.
// Ports: clk, reset (async low), flush, push/wdata, pop/rdata (head), count.
module sync_fifo #(
   parameter int DATA_WIDTH_P = 32,
   parameter int DEPTH_P      = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic                      push,
   input  logic [DATA_WIDTH_P-1:0]   wdata,
   input  logic                      pop,
   output logic [DATA_WIDTH_P-1:0]   rdata,
   output logic [$clog2(DEPTH_P):0]  count
);

   localparam int AW = $clog2(DEPTH_P);
   localparam int CW = AW + 1;

   logic [DATA_WIDTH_P-1:0] mem [DEPTH_P];
   logic [AW-1:0]           wr_ptr;
   logic [AW-1:0]           rd_ptr;
   logic                    do_push;
   logic                    do_pop;

   assign do_push = push && (count != CW'(DEPTH_P));
   assign do_pop  = pop && (count != '0);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH_P; i++) mem[i] <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: sequential word fetch with credit-limited requests,
// in-order response buffering and redirect flush toward decode.
// Ports: clk, reset (async low); i_redirect/i_redirect_pc from execute;
// o_mem_req/o_mem_addr/i_mem_gnt request side; i_mem_rvalid/i_mem_rdata
// response side; o_instr_valid/o_instr/o_instr_pc/i_instr_ready to decode.
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter int DATA_WIDTH_P = DATA_WIDTH,
   parameter int FIFO_DEPTH_P = 2,
   parameter logic [DATA_WIDTH_P-1:0] RESET_PC_P = DATA_WIDTH_P'(RESET_PC)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    i_redirect,
   input  logic [DATA_WIDTH_P-1:0] i_redirect_pc,
   output logic                    o_mem_req,
   output logic [DATA_WIDTH_P-1:0] o_mem_addr,
   input  logic                    i_mem_gnt,
   input  logic                    i_mem_rvalid,
   input  logic [DATA_WIDTH_P-1:0] i_mem_rdata,
   output logic                    o_instr_valid,
   output logic [DATA_WIDTH_P-1:0] o_instr,
   output logic [DATA_WIDTH_P-1:0] o_instr_pc,
   input  logic                    i_instr_ready
);

   localparam int CW = $clog2(FIFO_DEPTH_P) + 1;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH_P);

   fetch_state_e            state;
   fetch_state_e            state_d;
   logic [DATA_WIDTH_P-1:0] fetch_addr;
   logic [DATA_WIDTH_P-1:0] head_pc;
   logic [CW-1:0]           outstanding;
   logic [CW-1:0]           outstanding_d;
   logic [CW-1:0]           drop_cnt;
   logic [CW-1:0]           drop_cnt_d;
   logic [CW-1:0]           fifo_count;
   logic                    credit;
   logic                    grant;
   logic                    push;
   logic                    pop;

   // In-flight plus buffered never exceeds the buffer, so no response
   // ever needs to be refused.
   assign credit     = ({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_C;
   assign o_mem_req  = reset && credit && !i_redirect;
   assign o_mem_addr = fetch_addr;
   assign grant      = o_mem_req && i_mem_gnt;

   assign o_instr_valid = (fifo_count != '0);
   assign o_instr_pc    = head_pc;
   assign pop           = o_instr_valid && i_instr_ready && !i_redirect;

   always_comb begin
      state_d       = state;
      drop_cnt_d    = drop_cnt;
      push          = 1'b0;
      outstanding_d = outstanding + CW'(grant) - CW'(i_mem_rvalid);
      unique case (state)
         RUN:   push = i_mem_rvalid && !i_redirect;
         DRAIN: if (i_mem_rvalid) drop_cnt_d = drop_cnt - 1'b1;
      endcase
      // Everything still in flight after this cycle becomes stale.
      if (i_redirect) drop_cnt_d = outstanding - CW'(i_mem_rvalid);
      state_d = (drop_cnt_d != '0) ? DRAIN : RUN;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= RUN;
         fetch_addr  <= RESET_PC_P;
         head_pc     <= RESET_PC_P;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         state       <= state_d;
         outstanding <= outstanding_d;
         drop_cnt    <= drop_cnt_d;
         if (i_redirect) begin
            fetch_addr <= i_redirect_pc;
            head_pc    <= i_redirect_pc;
         end else begin
            if (grant) fetch_addr <= fetch_addr + 1'b1;
            if (pop)   head_pc    <= head_pc + 1'b1;
         end
      end
   end

   sync_fifo #(
      .DATA_WIDTH_P (DATA_WIDTH_P),
      .DEPTH_P      (FIFO_DEPTH_P)
   ) u_buf (
      .clk   (clk),
      .reset (reset),
      .flush (i_redirect),
      .push  (push),
      .wdata (i_mem_rdata),
      .pop   (pop),
      .rdata (o_instr),
      .count (fifo_count)
   );

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed scenarios against a small in-order
// memory model with selectable 1- or 2-cycle response latency.
module tb_instruction_fetch;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        i_redirect = 1'b0;
   logic [31:0] i_redirect_pc = '0;
   logic        o_mem_req;
   logic [31:0] o_mem_addr;
   logic        i_mem_gnt = 1'b1;
   logic        i_mem_rvalid = 1'b0;
   logic [31:0] i_mem_rdata = '0;
   logic        o_instr_valid;
   logic [31:0] o_instr;
   logic [31:0] o_instr_pc;
   logic        i_instr_ready = 1'b1;

   int tests = 0;
   int fails = 0;

   int          lat = 1;
   int          tb_out = 0;
   logic        gs = 1'b0;
   logic [31:0] g_addr = '0;
   logic [31:0] tb_fa = '0;
   logic        d1v = 1'b0, d2v = 1'b0;
   logic [31:0] d1a = '0, d2a = '0;
   logic [31:0] exp_pc = '0;

   always #5 clk = ~clk;

   instruction_fetch #(
      .DATA_WIDTH_P (32),
      .FIFO_DEPTH_P (4),
      .RESET_PC_P   (32'h0)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .i_redirect    (i_redirect),
      .i_redirect_pc (i_redirect_pc),
      .o_mem_req     (o_mem_req),
      .o_mem_addr    (o_mem_addr),
      .i_mem_gnt     (i_mem_gnt),
      .i_mem_rvalid  (i_mem_rvalid),
      .i_mem_rdata   (i_mem_rdata),
      .o_instr_valid (o_instr_valid),
      .o_instr       (o_instr),
      .o_instr_pc    (o_instr_pc),
      .i_instr_ready (i_instr_ready)
   );

   function automatic logic [31:0] mdata(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   // Grant sampling and outstanding tracking.
   always @(negedge clk) begin
      if (!reset) begin
         tb_out = 0;
         gs     = 1'b0;
      end else begin
         assert (!(i_mem_rvalid && tb_out == 0))
            else $error("protocol error: response with nothing outstanding");
         gs     = o_mem_req && i_mem_gnt;
         g_addr = o_mem_addr;
         tb_out = tb_out + int'(gs) - int'(i_mem_rvalid);
         if (gs) tb_fa = g_addr + 32'd1;
      end
   end

   // In-order memory, latency 1 or 2 cycles after grant.
   always @(posedge clk) begin
      #1;
      d2v = d1v;
      d2a = d1a;
      d1v = gs;
      d1a = g_addr;
      if (!reset) begin
         d1v = 1'b0;
         d2v = 1'b0;
      end
      i_mem_rvalid = (lat == 2) ? d2v : d1v;
      i_mem_rdata  = (lat == 2) ? mdata(d2a) : mdata(d1a);
   end

   task automatic test_reset();
      repeat (2) @(negedge clk);
      tests++;
      if (o_mem_req !== 1'b0) begin
         fails++;
         $display("FAIL reset_req got %b want 0", o_mem_req);
      end
      tests++;
      if (o_instr_valid !== 1'b0) begin
         fails++;
         $display("FAIL reset_valid got %b want 0", o_instr_valid);
      end
      tests++;
      if (o_instr !== 32'h0) begin
         fails++;
         $display("FAIL reset_instr got %h want 0", o_instr);
      end
      tests++;
      if (o_instr_pc !== 32'h0) begin
         fails++;
         $display("FAIL reset_pc got %h want 0", o_instr_pc);
      end
      @(posedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic test_stream();
      exp_pc = 32'h0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         tests++;
         if (o_mem_req !== 1'b1 || o_mem_addr !== 32'(k)) begin
            fails++;
            $display("FAIL stream_req c%0d got %b/%h want 1/%h",
                     k, o_mem_req, o_mem_addr, 32'(k));
         end
         tests++;
         if (k < 2) begin
            if (o_instr_valid !== 1'b0) begin
               fails++;
               $display("FAIL stream_startup c%0d valid got %b want 0",
                        k, o_instr_valid);
            end
         end else begin
            if (o_instr_valid !== 1'b1 || o_instr_pc !== exp_pc ||
                o_instr !== mdata(exp_pc)) begin
               fails++;
               $display("FAIL stream_out c%0d got %b/%h/%h want 1/%h/%h",
                        k, o_instr_valid, o_instr_pc, o_instr,
                        exp_pc, mdata(exp_pc));
            end
            exp_pc++;
         end
      end
   endtask

   task automatic test_stall();
      int npop = 0;
      @(posedge clk);
      #1 i_instr_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i == 0) begin
            tests++;
            if (o_instr_pc !== exp_pc) begin
               fails++;
               $display("FAIL stall_head got %h want %h", o_instr_pc, exp_pc);
            end
         end
      end
      tests++;
      if (o_mem_req !== 1'b0) begin
         fails++;
         $display("FAIL stall_req got %b want 0", o_mem_req);
      end
      tests++;
      if (o_instr_valid !== 1'b1 || o_instr_pc !== exp_pc) begin
         fails++;
         $display("FAIL stall_hold got %b/%h want 1/%h",
                  o_instr_valid, o_instr_pc, exp_pc);
      end
      @(posedge clk);
      #1 i_instr_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (o_instr_valid) begin
            tests++;
            if (o_instr_pc !== exp_pc || o_instr !== mdata(exp_pc)) begin
               fails++;
               $display("FAIL stall_resume got %h/%h want %h/%h",
                        o_instr_pc, o_instr, exp_pc, mdata(exp_pc));
            end
            exp_pc++;
            npop++;
         end
      end
      tests++;
      if (npop != 12) begin
         fails++;
         $display("FAIL stall_gapless pops got %0d want 12", npop);
      end
   endtask

   task automatic test_gnt_hold();
      @(posedge clk);
      #1 i_mem_gnt = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         tests++;
         if (o_mem_req !== 1'b1 || o_mem_addr !== tb_fa) begin
            fails++;
            $display("FAIL gnt_hold c%0d got %b/%h want 1/%h",
                     i, o_mem_req, o_mem_addr, tb_fa);
         end
         if (o_instr_valid) begin
            tests++;
            if (o_instr_pc !== exp_pc || o_instr !== mdata(exp_pc)) begin
               fails++;
               $display("FAIL gnt_hold_out got %h/%h want %h/%h",
                        o_instr_pc, o_instr, exp_pc, mdata(exp_pc));
            end
            exp_pc++;
         end
      end
      @(posedge clk);
      #1;
      lat       = 2;
      i_mem_gnt = 1'b1;
   endtask

   task automatic test_redirect();
      bit got = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (o_instr_valid) begin
            tests++;
            if (o_instr_pc !== exp_pc || o_instr !== mdata(exp_pc)) begin
               fails++;
               $display("FAIL lat2_out got %h/%h want %h/%h",
                        o_instr_pc, o_instr, exp_pc, mdata(exp_pc));
            end
            exp_pc++;
         end
      end
      @(posedge clk);
      #1;
      i_redirect    = 1'b1;
      i_redirect_pc = 32'h100;
      @(negedge clk);
      tests++;
      if (o_mem_req !== 1'b0 || tb_out != 2) begin
         fails++;
         $display("FAIL redir_cycle req/inflight got %b/%0d want 0/2",
                  o_mem_req, tb_out);
      end
      @(posedge clk);
      #1 i_redirect = 1'b0;
      @(negedge clk);
      tests++;
      if (o_instr_valid !== 1'b0 || o_mem_req !== 1'b1 ||
          o_mem_addr !== 32'h100) begin
         fails++;
         $display("FAIL redir_next got %b/%b/%h want 0/1/00000100",
                  o_instr_valid, o_mem_req, o_mem_addr);
      end
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         if (o_instr_valid) got = 1;
      end
      tests++;
      if (!got || o_instr_pc !== 32'h100 || o_instr !== mdata(32'h100)) begin
         fails++;
         $display("FAIL redir_first got %b/%h/%h want 1/00000100/%h",
                  got, o_instr_pc, o_instr, mdata(32'h100));
      end
      @(negedge clk);
      tests++;
      if (o_instr_valid !== 1'b1 || o_instr_pc !== 32'h101 ||
          o_instr !== mdata(32'h101)) begin
         fails++;
         $display("FAIL redir_second got %b/%h/%h want 1/00000101/%h",
                  o_instr_valid, o_instr_pc, o_instr, mdata(32'h101));
      end
      exp_pc = 32'h102;
   endtask

   task automatic test_redirect_pop();
      bit got = 0;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1;
      i_redirect    = 1'b1;
      i_redirect_pc = 32'h200;
      @(negedge clk);
      tests++;
      if (i_mem_rvalid !== 1'b1 || o_instr_valid !== 1'b1) begin
         fails++;
         $display("FAIL redir_pop_setup rvalid/valid got %b/%b want 1/1",
                  i_mem_rvalid, o_instr_valid);
      end
      @(posedge clk);
      #1 i_redirect = 1'b0;
      @(negedge clk);
      tests++;
      if (o_instr_valid !== 1'b0) begin
         fails++;
         $display("FAIL redir_pop_flush valid got %b want 0", o_instr_valid);
      end
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         if (o_instr_valid) got = 1;
      end
      tests++;
      if (!got || o_instr_pc !== 32'h200 || o_instr !== mdata(32'h200)) begin
         fails++;
         $display("FAIL redir_pop_first got %b/%h/%h want 1/00000200/%h",
                  got, o_instr_pc, o_instr, mdata(32'h200));
      end
   endtask

   task automatic test_reset_wrap();
      bit got = 0;
      @(posedge clk);
      #1 i_instr_ready = 1'b0;
      repeat (10) @(negedge clk);
      tests++;
      if (o_instr_valid !== 1'b1 || o_mem_req !== 1'b0) begin
         fails++;
         $display("FAIL full_setup valid/req got %b/%b want 1/0",
                  o_instr_valid, o_mem_req);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      lat   = 1;
      @(negedge clk);
      tests++;
      if (o_instr_valid !== 1'b0 || o_mem_req !== 1'b0) begin
         fails++;
         $display("FAIL midreset valid/req got %b/%b want 0/0",
                  o_instr_valid, o_mem_req);
      end
      @(posedge clk);
      #1;
      reset         = 1'b1;
      i_instr_ready = 1'b1;
      @(negedge clk);
      tests++;
      if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h0) begin
         fails++;
         $display("FAIL restart_req got %b/%h want 1/00000000",
                  o_mem_req, o_mem_addr);
      end
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         if (o_instr_valid) got = 1;
      end
      tests++;
      if (!got || o_instr_pc !== 32'h0 || o_instr !== mdata(32'h0)) begin
         fails++;
         $display("FAIL restart_first got %b/%h/%h want 1/00000000/%h",
                  got, o_instr_pc, o_instr, mdata(32'h0));
      end
      @(posedge clk);
      #1;
      i_redirect    = 1'b1;
      i_redirect_pc = 32'hFFFF_FFFF;
      @(posedge clk);
      #1 i_redirect = 1'b0;
      @(negedge clk);
      tests++;
      if (o_mem_req !== 1'b1 || o_mem_addr !== 32'hFFFF_FFFF) begin
         fails++;
         $display("FAIL wrap_req0 got %b/%h want 1/ffffffff",
                  o_mem_req, o_mem_addr);
      end
      @(negedge clk);
      tests++;
      if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h0) begin
         fails++;
         $display("FAIL wrap_req1 got %b/%h want 1/00000000",
                  o_mem_req, o_mem_addr);
      end
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         if (o_instr_valid) got = 1;
      end
      tests++;
      if (!got || o_instr_pc !== 32'hFFFF_FFFF ||
          o_instr !== mdata(32'hFFFF_FFFF)) begin
         fails++;
         $display("FAIL wrap_out0 got %b/%h/%h want 1/ffffffff/%h",
                  got, o_instr_pc, o_instr, mdata(32'hFFFF_FFFF));
      end
      @(negedge clk);
      tests++;
      if (o_instr_valid !== 1'b1 || o_instr_pc !== 32'h0 ||
          o_instr !== mdata(32'h0)) begin
         fails++;
         $display("FAIL wrap_out1 got %b/%h/%h want 1/00000000/%h",
                  o_instr_valid, o_instr_pc, o_instr, mdata(32'h0));
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_gnt_hold();
      test_redirect();
      test_redirect_pop();
      test_reset_wrap();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout tests=%0d failed=%0d", tests, fails);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage directly downstream of the program counter. Owns the sequential fetch address, issues word reads to instruction memory over a request/grant interface, buffers in-order responses in a small FIFO, and presents instruction + PC pairs to decode with a valid/ready handshake. A redirect from execute reloads the address and discards all buffered and in-flight fetches.

## Interface
- DATA_WIDTH_P, 32: width of address, PC and instruction.
- FIFO_DEPTH_P, 2: instruction buffer entries; also the maximum number of outstanding requests. Must be a power of two, ≥2.
- RESET_PC_P, 0: fetch address after reset.

- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_redirect  in  1  one-cycle pulse: discard everything and fetch from i_redirect_pc.
- i_redirect_pc  in  DATA_WIDTH_P  new fetch address (word address).
- o_mem_req  out  1  read request valid.
- o_mem_addr  out  DATA_WIDTH_P  word address of request.
- i_mem_gnt  in  1  request accepted this cycle.
- i_mem_rvalid  in  1  read data valid; responses in request order, ≥1 cycle after grant.
- i_mem_rdata  in  DATA_WIDTH_P  instruction word.
- o_instr_valid  out  1  FIFO head valid.
- o_instr  out  DATA_WIDTH_P  instruction at FIFO head.
- o_instr_pc  out  DATA_WIDTH_P  word address of o_instr.
- i_instr_ready  in  1  decode accepts head.

## Operation
- Registers: fetch_addr, head_pc, outstanding (0..FIFO_DEPTH_P), drop_cnt (0..FIFO_DEPTH_P), FIFO count/pointers.
- Credit rule: o_mem_req = (outstanding + fifo_count < FIFO_DEPTH_P) && !i_redirect. FIFO therefore never overflows; no response is ever refused.
- Grant (o_mem_req && i_mem_gnt): fetch_addr += 1 (word addressing, wraps modulo 2^DATA_WIDTH_P); outstanding += 1.
- Response (i_mem_rvalid): outstanding -= 1; if drop_cnt > 0, drop_cnt -= 1 and data discarded, else i_mem_rdata pushed to FIFO.
- Pop (o_instr_valid && i_instr_ready): head_pc += 1 (wraps); FIFO count -= 1.
- Grant, response and pop in the same cycle are all applied; counters use net change.
- Redirect: fetch_addr ← i_redirect_pc, head_pc ← i_redirect_pc, FIFO emptied, drop_cnt ← outstanding − (response this cycle ? 1 : 0) (+ drop_cnt residue likewise decremented), outstanding updated normally. A response or pop in the redirect cycle is discarded/ignored. No request is issued in the redirect cycle.
- Two-state FSM: RUN (drop_cnt = 0) and DRAIN (drop_cnt > 0). Requests are permitted in both; only response routing differs. DRAIN → RUN when the last stale response arrives.
- Response with outstanding = 0 is a protocol error; bench asserts it never occurs.

## Timing
- Reset values: o_mem_req 0 while reset asserted; fetch_addr = head_pc = RESET_PC_P; outstanding = drop_cnt = 0; FIFO empty; o_instr_valid 0; o_instr and o_instr_pc 0 / RESET_PC_P.
- First request: o_mem_req 1 in the first cycle after reset deasserts, o_mem_addr = RESET_PC_P.
- o_mem_addr = fetch_addr combinationally; o_mem_req/addr held stable until granted.
- Response to o_instr_valid: 1 cycle (registered FIFO write, head visible next cycle). Minimum grant-to-valid with 1-cycle memory: 2 cycles.
- Sustained throughput 1 instruction/cycle with FIFO_DEPTH_P ≥ memory latency + 1.
- Redirect: o_instr_valid 0 in the following cycle; new request issued the cycle after the pulse.
- Reset mid-operation: all state returns to reset values immediately; in-flight memory responses arriving after reset are not tracked (memory is reset together).

## Structure
- Shared CPU package: DATA_WIDTH default, RESET_PC, FSM state encoding (RUN/DRAIN).
- One sub-module: sync_fifo (DATA_WIDTH_P × FIFO_DEPTH_P, push/pop/flush, count, registered storage), reusable by later stages.

## Test plan
- Reset release, memory grants every cycle with 1-cycle latency, ready=1 -> instructions at PCs 0,1,2,3… one per cycle after 2-cycle start-up; o_mem_addr 0,1,2,….
- i_instr_ready=0 for 10 cycles -> at most FIFO_DEPTH_P requests outstanding+buffered, o_mem_req drops to 0, no data lost; release -> PCs resume in order without gaps.
- Redirect to 0x100 with 2 requests in flight -> both responses dropped, next o_instr_pc = 0x100 with the data for address 0x100.
- Redirect in same cycle as response and pop -> response discarded, head not advanced, next valid PC = redirect target.
- i_mem_gnt held low 5 cycles -> o_mem_req/o_mem_addr stable throughout.
- Assert reset mid-stream with FIFO full -> next cycle o_instr_valid 0, o_mem_req 0; after release fetch restarts at RESET_PC_P; fetch_addr 0xFFFFFFFF wraps to 0.
